// File: rtl/mapu_arb.sv
// rtl/mapu_arb.sv - round-robin arbiter and job sequencer sharing one mapu between two requesters
module mapu_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int BEATS_IN   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req_vld,
  input  logic [2*OP_WIDTH-1:0]   req_op,
  input  logic [2*DATA_WIDTH-1:0] req_r0,
  input  logic [2*DATA_WIDTH-1:0] req_r1,
  input  logic [2*DATA_WIDTH-1:0] req_r2,
  output logic [1:0]              req_rdy,
  output logic [1:0]              rsp_vld,
  output logic [DATA_WIDTH-1:0]   rsp_r0,
  output logic [DATA_WIDTH-1:0]   rsp_r1,
  output logic [DATA_WIDTH-1:0]   rsp_r2,
  output logic                    rsp_of,
  input  logic [1:0]              rsp_rdy,
  output logic                    m_en,
  output logic [OP_WIDTH-1:0]     m_op,
  output logic                    m_vld,
  output logic [DATA_WIDTH-1:0]   m_r0,
  output logic [DATA_WIDTH-1:0]   m_r1,
  output logic [DATA_WIDTH-1:0]   m_r2,
  input  logic                    m_rdy,
  input  logic                    m_o_vld,
  input  logic [DATA_WIDTH-1:0]   m_o_r0,
  input  logic [DATA_WIDTH-1:0]   m_o_r1,
  input  logic [DATA_WIDTH-1:0]   m_o_r2,
  input  logic                    m_of,
  output logic                    m_o_rdy,
  output logic [1:0]              of_sticky,
  input  logic [1:0]              of_clr,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BEATS_IN - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [3:0]            r_beat_cnt;
  logic [OP_WIDTH-1:0]   r_op;
  logic [1:0]            r_of_sticky;
  logic                  w_grant_sel;
  logic [OP_WIDTH-1:0]   w_grant_op;
  logic                  w_feed_hs;
  logic                  w_drain_hs;

  // On a tie the requester that did not go last wins.
  assign w_grant_sel = (req_vld == 2'b11) ? ~r_last_grant : req_vld[1];
  assign w_grant_op  = w_grant_sel ? req_op[OP_WIDTH +: OP_WIDTH] : req_op[0 +: OP_WIDTH];
  assign w_feed_hs   = (r_state == FEED) & req_vld[r_grant] & m_rdy;
  assign w_drain_hs  = (r_state == DRAIN) & m_o_vld & rsp_rdy[r_grant];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= 4'd0;
      r_op         <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |req_vld) begin
        r_grant <= w_grant_sel;
        r_op    <= w_grant_op;
      end
      if (w_feed_hs) begin
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? 4'd0 : r_beat_cnt + 4'd1;
      end
      if (w_drain_hs) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // A set from the result handshake takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_of_sticky <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_drain_hs && m_of && (r_grant == n[0])) begin
          r_of_sticky[n] <= 1'b1;
        end else if (of_clr[n]) begin
          r_of_sticky[n] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    req_rdy = 2'b00;
    rsp_vld = 2'b00;
    m_vld   = 1'b0;
    m_o_rdy = 1'b0;
    m_r0    = '0;
    m_r1    = '0;
    m_r2    = '0;
    case (r_state)
      IDLE: begin
        if (|req_vld) w_next = FEED;
      end
      FEED: begin
        m_vld            = req_vld[r_grant];
        m_r0             = r_grant ? req_r0[DATA_WIDTH +: DATA_WIDTH] : req_r0[0 +: DATA_WIDTH];
        m_r1             = r_grant ? req_r1[DATA_WIDTH +: DATA_WIDTH] : req_r1[0 +: DATA_WIDTH];
        m_r2             = r_grant ? req_r2[DATA_WIDTH +: DATA_WIDTH] : req_r2[0 +: DATA_WIDTH];
        req_rdy[r_grant] = m_rdy;
        if (w_feed_hs && r_beat_cnt == LAST_BEAT) w_next = DRAIN;
      end
      DRAIN: begin
        rsp_vld[r_grant] = m_o_vld;
        m_o_rdy          = rsp_rdy[r_grant];
        if (w_drain_hs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign rsp_r0    = m_o_r0;
  assign rsp_r1    = m_o_r1;
  assign rsp_r2    = m_o_r2;
  assign rsp_of    = m_of;
  assign m_op      = r_op;
  assign m_en      = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign of_sticky = r_of_sticky;

endmodule

// File: tb/tb_mapu_arb.sv
// tb/tb_mapu_arb.sv - directed self-checking bench for mapu_arb
module tb_mapu_arb;

  localparam int DW = 32;
  localparam int OW = 3;
  localparam int BI = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_vld;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_r0, req_r1, req_r2;
  logic [1:0]      req_rdy;
  logic [1:0]      rsp_vld;
  logic [DW-1:0]   rsp_r0, rsp_r1, rsp_r2;
  logic            rsp_of;
  logic [1:0]      rsp_rdy;
  logic            m_en;
  logic [OW-1:0]   m_op;
  logic            m_vld;
  logic [DW-1:0]   m_r0, m_r1, m_r2;
  logic            m_rdy;
  logic            m_o_vld;
  logic [DW-1:0]   m_o_r0, m_o_r1, m_o_r2;
  logic            m_of;
  logic            m_o_rdy;
  logic [1:0]      of_sticky;
  logic [1:0]      of_clr;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  mapu_arb #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .BEATS_IN(BI)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_op(req_op), .req_r0(req_r0), .req_r1(req_r1), .req_r2(req_r2),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_r0(rsp_r0), .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
    .rsp_of(rsp_of), .rsp_rdy(rsp_rdy), .m_en(m_en), .m_op(m_op), .m_vld(m_vld),
    .m_r0(m_r0), .m_r1(m_r1), .m_r2(m_r2), .m_rdy(m_rdy), .m_o_vld(m_o_vld),
    .m_o_r0(m_o_r0), .m_o_r1(m_o_r1), .m_o_r2(m_o_r2), .m_of(m_of), .m_o_rdy(m_o_rdy),
    .of_sticky(of_sticky), .of_clr(of_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bd(input int r, input int b, input int row);
    return 32'hA000_0000 | 32'(r << 16) | 32'(b << 8) | 32'(row);
  endfunction

  function automatic logic [31:0] rd(input int r, input int row);
    return 32'h5E00_0000 | 32'(r << 8) | 32'(row);
  endfunction

  task automatic set_beat(input int b);
    for (int r = 0; r < 2; r++) begin
      req_r0[r*DW +: DW] = bd(r, b, 0);
      req_r1[r*DW +: DW] = bd(r, b, 1);
      req_r2[r*DW +: DW] = bd(r, b, 2);
    end
  endtask

  task automatic drive_idle();
    req_vld = 2'b00; req_op = '0; req_r0 = '0; req_r1 = '0; req_r2 = '0;
    rsp_rdy = 2'b00; m_rdy = 1'b0; m_o_vld = 1'b0; m_of = 1'b0;
    m_o_r0 = '0; m_o_r1 = '0; m_o_r2 = '0; of_clr = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_m_en"}, m_en, 0);
    check({tag, "_m_op"}, m_op, 0);
    check({tag, "_req_rdy"}, req_rdy, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_m_vld"}, m_vld, 0);
    check({tag, "_m_o_rdy"}, m_o_rdy, 0);
    check({tag, "_m_r0"}, m_r0, 0);
    check({tag, "_of_sticky"}, of_sticky, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Entered and left 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_job(input logic [1:0] vld, input int g, input logic [2:0] op0, input logic [2:0] op1,
                        input logic [3:0] rdy_pat, input int stall, input logic of,
                        input logic clr_hs, input logic op_chg);
    int beat = 0;
    int k = 0;
    logic [2:0] exp_op;
    exp_op  = (g == 1) ? op1 : op0;
    req_vld = vld;
    req_op  = {op1, op0};
    set_beat(0);
    m_rdy   = rdy_pat[0];
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_req_rdy", req_rdy, 0);
    @(posedge clk); #1;
    if (op_chg) req_op = {op1, 3'd5};
    while (beat < BI && k < 40) begin
      @(negedge clk);
      check("feed_op", m_op, exp_op);
      check("feed_en", m_en, 1);
      check("feed_other_rdy", req_rdy[1-g], 0);
      check("feed_m_o_rdy", m_o_rdy, 0);
      if (m_rdy) begin
        check("feed_vld", m_vld, 1);
        check("feed_rdy", req_rdy[g], 1);
        check("feed_r0", m_r0, bd(g, beat, 0));
        check("feed_r2", m_r2, bd(g, beat, 2));
      end else begin
        check("stall_rdy", req_rdy[g], 0);
      end
      @(posedge clk); #1;
      if (m_rdy) begin
        beat++;
        set_beat(beat);
      end
      k++;
      m_rdy = rdy_pat[k % 4];
    end
    if (beat < BI) check("feed_timeout", 64'(beat), 64'(BI));
    m_o_vld = 1'b1;
    m_o_r0  = rd(g, 0);
    m_o_r1  = rd(g, 1);
    m_o_r2  = rd(g, 2);
    m_of    = of;
    rsp_rdy = 2'b00;
    repeat (stall) begin
      @(negedge clk);
      check("drain_stall_vld", rsp_vld, 64'(2'b01 << g));
      check("drain_stall_ordy", m_o_rdy, 0);
      check("drain_m_vld", m_vld, 0);
      check("drain_m_r0", m_r0, 0);
      @(posedge clk); #1;
    end
    rsp_rdy = 2'(2'b01 << g);
    if (clr_hs) of_clr = 2'(2'b01 << g);
    @(negedge clk);
    check("rsp_vld", rsp_vld, 64'(2'b01 << g));
    check("rsp_r0", rsp_r0, rd(g, 0));
    check("rsp_r2", rsp_r2, rd(g, 2));
    check("rsp_of", rsp_of, of);
    check("drain_m_o_rdy", m_o_rdy, 1);
    check("drain_req_rdy", req_rdy, 0);
    check("drain_m_vld_hs", m_vld, 0);
    @(posedge clk); #1;
    m_o_vld = 1'b0; rsp_rdy = 2'b00; of_clr = 2'b00; m_of = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    do_job(2'b01, 0, 3'd3, 3'd0, 4'b1111, 0, 1'b0, 1'b0, 1'b0);
    req_vld = 2'b00;
    check("single_busy_after", busy, 0);

    do_reset();
    for (int i = 0; i < 4; i++) do_job(2'b11, i % 2, 3'd2, 3'd6, 4'b1111, 0, 1'b0, 1'b0, 1'b0);
    req_vld = 2'b00;

    do_job(2'b10, 1, 3'd0, 3'd4, 4'b1001, 3, 1'b0, 1'b0, 1'b0);

    do_job(2'b10, 1, 3'd0, 3'd7, 4'b1111, 0, 1'b1, 1'b0, 1'b0);
    req_vld = 2'b00;
    check("of_set", of_sticky, 2'b10);
    of_clr = 2'b10;
    @(posedge clk); #1;
    of_clr = 2'b00;
    check("of_clr", of_sticky, 2'b00);
    do_job(2'b10, 1, 3'd0, 3'd7, 4'b1111, 0, 1'b1, 1'b1, 1'b0);
    req_vld = 2'b00;
    check("of_set_wins", of_sticky, 2'b10);

    do_job(2'b01, 0, 3'd2, 3'd0, 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    req_vld = 2'b00;
    check("op_latch_sticky_kept", of_sticky, 2'b10);

    req_vld = 2'b01; req_op = {3'd0, 3'd3}; set_beat(0); m_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midfeed_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    drive_idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_job(2'b11, 0, 3'd1, 3'd4, 4'b1111, 0, 1'b0, 1'b0, 1'b0);
    req_vld = 2'b00;
    check("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mapu_arb.md
Name: mapu_arb

Overview:
- Round-robin arbiter and job sequencer that shares one Matrix APU (mapu_top) between two requesters.
- A job is: the operation code, then BEATS_IN input beats (3 rows per beat), then exactly one 3-row result beat with an overflow flag.
- The arbiter grants one requester per job, holds the op stable, forwards input beats, and routes the result beat back to the granted requester.
- It sits between the block-level requester interfaces and the mapu_top control and data ports.

Parameters:
- DATA_WIDTH, 32, width of each row signal (r0/r1/r2), matching mapu_top DATA_WIDTH.
- OP_WIDTH, 3, width of the mapu operation code.
- BEATS_IN, 2, input beats per job; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_vld  in  2  per-requester input beat valid; bit n belongs to requester n.
- req_op  in  2*OP_WIDTH  per-requester op; slice n is [n*OP_WIDTH +: OP_WIDTH].
- req_r0/req_r1/req_r2  in  2*DATA_WIDTH each  per-requester input rows.
- req_rdy  out  2  per-requester input beat ready.
- rsp_vld  out  2  per-requester result valid.
- rsp_r0/rsp_r1/rsp_r2  out  DATA_WIDTH each  result rows, shared by both requesters, qualified by rsp_vld.
- rsp_of  out  1  overflow flag of the result, qualified by rsp_vld.
- rsp_rdy  in  2  per-requester result ready.
- m_en  out  1  to mapu i_en.
- m_op  out  OP_WIDTH  to mapu i_op.
- m_vld  out  1  to mapu i_vld.
- m_r0/m_r1/m_r2  out  DATA_WIDTH each  to mapu i_r0/i_r1/i_r2.
- m_rdy  in  1  from mapu o_rdy.
- m_o_vld  in  1  from mapu o_vld.
- m_o_r0/m_o_r1/m_o_r2  in  DATA_WIDTH each  from mapu o_r0/o_r1/o_r2.
- m_of  in  1  from mapu o_of.
- m_o_rdy  out  1  to mapu i_rdy.
- of_sticky  out  2  per-requester sticky overflow status.
- of_clr  in  2  per-requester sticky overflow clear.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low; all state clears on assertion.
- Reset values:
  - state = IDLE, grant = 0, beat_cnt = 0, last_grant = 1 (so requester 0 wins the first tie).
  - m_op = 0, m_en = 0, of_sticky = 0.
  - All valid and ready outputs = 0.
- FSM states: IDLE, FEED, DRAIN.
- IDLE:
  - req_rdy = 0, m_vld = 0, m_o_rdy = 0.
  - If any req_vld bit is set, register grant and go to FEED next cycle.
  - Grant rule with one requester valid: that requester.
  - Grant rule with both valid: the requester != last_grant.
  - On grant, latch m_op from the granted requester's req_op slice.
  - Request-to-first-transfer latency: 1 cycle.
- FEED:
  - Combinational pass-through from the granted requester g: m_vld = req_vld[g], m_r* = req_r*[g], req_rdy[g] = m_rdy.
  - The non-granted requester sees req_rdy = 0.
  - beat_cnt increments on m_vld & m_rdy.
  - On the handshake where beat_cnt == BEATS_IN-1: clear beat_cnt and go to DRAIN.
  - req_op is ignored after grant; a change mid-job has no effect on m_op.
- DRAIN:
  - rsp_vld[g] = m_o_vld, rsp_r* = m_o_r*, rsp_of = m_of, m_o_rdy = rsp_rdy[g].
  - On m_o_vld & rsp_rdy[g]: last_grant <= g, go to IDLE.
  - If m_of is set on that handshake, of_sticky[g] <= 1.
  - Back-to-back jobs: IDLE always lasts exactly 1 cycle between jobs.
- m_en = 1 in FEED and DRAIN, 0 in IDLE.
- When not in DRAIN: rsp_vld = 0, m_o_rdy = 0, and rsp_r* and rsp_of still pass through (don't-care).
- m_r* = 0 outside FEED.
- of_clr[n] clears of_sticky[n]. If a set and a clear of the same bit coincide, the set wins.
- Stray m_o_vld in IDLE or FEED is not accepted (m_o_rdy = 0).
- Reset mid-job: immediate return to IDLE with all outputs at reset values. Partial beats are discarded; the mapu is reset by the same reset_n.
- No timeouts: the arbiter waits indefinitely on m_rdy, m_o_vld and rsp_rdy.

Test Plan:
- Single job: reset, requester 0 only, op=3, BEATS_IN=2 beats, mapu ready always, result beat with m_of=0.
  - Response: grant 1 cycle after req_vld; two m_vld handshakes carrying the beat data; m_op=3 throughout; rsp_vld[0] with result rows, rsp_of=0; busy back to 0.
- Simultaneous requests from reset: both req_vld=1 continuously.
  - Response: job order 0,1,0,1, strictly alternating; non-granted req_rdy stays 0.
- Backpressure: m_rdy toggles 1,0,0,1 during FEED; rsp_rdy[1]=0 for 3 cycles during DRAIN.
  - Response: beat_cnt advances only on handshakes; m_o_rdy=0 while rsp_rdy=0; result delivered once; no beat lost or duplicated.
- Overflow: requester 1 job returns m_of=1; then of_clr[1] pulsed; then a simultaneous m_of set and of_clr on the same requester.
  - Response: of_sticky=2'b10 after the handshake; cleared to 0 by of_clr; set wins on the coincident cycle.
- Op latch: requester 0 changes req_op from 2 to 5 after grant.
  - Response: m_op stays 2 until the job ends.
- Reset mid-FEED after 1 of 2 beats.
  - Response: all outputs at reset values; next job starts with beat_cnt=0 and requester 0 winning a tie.
